// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider: NUM_CH square-wave outputs with
// rising-edge tick strobes, glitch-free half-period updates, gating and phase sync.
module clk_divider_multi #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 16,
    parameter int DEFAULT_HALF = 3,
    parameter int CH_W         = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_half,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pend
);

    localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);

    // Terminal count H_eff-1, where a programmed half-period of 0 behaves as 1.
    function automatic logic [CNT_W-1:0] last_cnt(input logic [CNT_W-1:0] half);
        return (half == '0) ? '0 : half - 1'b1;
    endfunction

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] half_cur_q, half_cur_d;
        logic [CNT_W-1:0] half_pend_q, half_pend_d;
        logic             clk_out_q, clk_out_d;
        logic             tick_q, tick_d;
        logic             pend_q, pend_d;
        logic             wr_hit;
        logic             wrap;
        logic             apply;

        // Channel indices at or above NUM_CH have no matching block, so such writes fall away.
        assign wr_hit = wr_en && (wr_ch == CH_W'(i));
        assign wrap   = (cnt_q >= last_cnt(half_cur_q));

        always_comb begin
            cnt_d     = cnt_q;
            clk_out_d = clk_out_q;
            tick_d    = 1'b0;
            apply     = 1'b0;
            if (!ch_en[i]) begin
                cnt_d     = '0;
                clk_out_d = 1'b0;
                apply     = pend_q;
            end else if (sync) begin
                cnt_d     = '0;
                clk_out_d = 1'b0;
                apply     = pend_q;
            end else if (wrap) begin
                cnt_d     = '0;
                clk_out_d = ~clk_out_q;
                tick_d    = ~clk_out_q;
                apply     = pend_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            // New half-periods only take effect where cnt restarts at 0, so no overrun is possible.
            half_cur_d  = apply ? half_pend_q : half_cur_q;
            half_pend_d = wr_hit ? wr_half : half_pend_q;
            // A write landing on an apply edge keeps the channel pending for its new value.
            pend_d      = wr_hit | (pend_q & ~apply);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q       <= '0;
                half_cur_q  <= HALF_RST;
                half_pend_q <= HALF_RST;
                clk_out_q   <= 1'b0;
                tick_q      <= 1'b0;
                pend_q      <= 1'b0;
            end else begin
                cnt_q       <= cnt_d;
                half_cur_q  <= half_cur_d;
                half_pend_q <= half_pend_d;
                clk_out_q   <= clk_out_d;
                tick_q      <= tick_d;
                pend_q      <= pend_d;
            end
        end

        assign clk_out[i] = clk_out_q;
        assign tick[i]    = tick_q;
        assign pend[i]    = pend_q;
    end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed self-checking bench for clk_divider_multi (4 channels, 3-bit channel select).
module tb_clk_divider_multi;

    logic        clk;
    logic        rst;
    logic [3:0]  ch_en;
    logic        sync;
    logic        wr_en;
    logic [2:0]  wr_ch;
    logic [15:0] wr_half;
    logic [3:0]  clk_out;
    logic [3:0]  tick;
    logic [3:0]  pend;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_c [8];
    logic [3:0] exp_t [8];

    clk_divider_multi #(
        .NUM_CH(4), .CNT_W(16), .DEFAULT_HALF(3), .CH_W(3)
    ) dut (
        .clk(clk), .rst(rst), .ch_en(ch_en), .sync(sync),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_half(wr_half),
        .clk_out(clk_out), .tick(tick), .pend(pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [13:0] pc;
        logic [13:0] pt;
        pc = 14'b00011100011100;
        pt = 14'b00000100000100;
        #1;
        total++; if (clk_out !== 4'h0) begin bad++; $display("FAIL reset_clk_out got=%b want=0000", clk_out); end
        total++; if (tick !== 4'h0) begin bad++; $display("FAIL reset_tick got=%b want=0000", tick); end
        total++; if (pend !== 4'h0) begin bad++; $display("FAIL reset_pend got=%b want=0000", pend); end
        step(); step();
        rst = 1'b0;
        for (int k = 0; k < 14; k++) begin
            step();
            total++;
            if (clk_out !== {4{pc[k]}}) begin bad++; $display("FAIL default_clk edge=%0d got=%b want=%b", k+1, clk_out, {4{pc[k]}}); end
            total++;
            if (tick !== {4{pt[k]}}) begin bad++; $display("FAIL default_tick edge=%0d got=%b want=%b", k+1, tick, {4{pt[k]}}); end
        end
    endtask

    task automatic test_write_mid();
        logic [17:0] pc;
        logic [17:0] pt;
        logic [17:0] pp;
        pc = 18'b011111000001111100;
        pt = 18'b000001000000000100;
        pp = 18'b000000000000000011;
        sync = 1'b1;
        step();
        sync = 1'b0;
        total++; if (clk_out !== 4'h0) begin bad++; $display("FAIL wmid_sync_clk got=%b want=0000", clk_out); end
        wr_en = 1'b1; wr_ch = 3'd1; wr_half = 16'd5;
        for (int k = 0; k < 18; k++) begin
            step();
            wr_en = 1'b0;
            total++;
            if (clk_out[1] !== pc[k]) begin bad++; $display("FAIL wmid_clk1 edge=%0d got=%b want=%b", k+1, clk_out[1], pc[k]); end
            total++;
            if (tick[1] !== pt[k]) begin bad++; $display("FAIL wmid_tick1 edge=%0d got=%b want=%b", k+1, tick[1], pt[k]); end
            total++;
            if (pend[1] !== pp[k]) begin bad++; $display("FAIL wmid_pend1 edge=%0d got=%b want=%b", k+1, pend[1], pp[k]); end
        end
    endtask

    task automatic test_fast();
        logic [1:0] want;
        wr_en = 1'b1; wr_ch = 3'd2; wr_half = 16'd0;
        step();
        wr_ch = 3'd3; wr_half = 16'd1;
        step();
        wr_en = 1'b0;
        step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        total++; if (pend !== 4'h0) begin bad++; $display("FAIL fast_pend got=%b want=0000", pend); end
        total++; if (clk_out !== 4'h0) begin bad++; $display("FAIL fast_sync_clk got=%b want=0000", clk_out); end
        for (int k = 1; k <= 6; k++) begin
            step();
            want = (k % 2 == 1) ? 2'b11 : 2'b00;
            total++;
            if (clk_out[3:2] !== want) begin bad++; $display("FAIL fast_clk edge=%0d got=%b want=%b", k, clk_out[3:2], want); end
            total++;
            if (tick[3:2] !== want) begin bad++; $display("FAIL fast_tick edge=%0d got=%b want=%b", k, tick[3:2], want); end
        end
    endtask

    task automatic test_sync();
        exp_c = '{4'b1000, 4'b0000, 4'b1001, 4'b0011, 4'b1011, 4'b0010, 4'b1110, 4'b0100};
        exp_t = '{4'b1000, 4'b0000, 4'b1001, 4'b0010, 4'b1000, 4'b0000, 4'b1100, 4'b0000};
        wr_en = 1'b1; wr_ch = 3'd0; wr_half = 16'd3;
        step();
        wr_ch = 3'd2; wr_half = 16'd7;
        step();
        wr_ch = 3'd1; wr_half = 16'd4;
        step();
        wr_en = 1'b0;
        total++; if (pend[1] !== 1'b1) begin bad++; $display("FAIL sync_pre_pend1 got=%b want=1", pend[1]); end
        sync = 1'b1;
        step();
        sync = 1'b0;
        total++; if (clk_out !== 4'h0) begin bad++; $display("FAIL sync_clk got=%b want=0000", clk_out); end
        total++; if (tick !== 4'h0) begin bad++; $display("FAIL sync_tick got=%b want=0000", tick); end
        total++; if (pend !== 4'h0) begin bad++; $display("FAIL sync_pend got=%b want=0000", pend); end
        for (int k = 0; k < 8; k++) begin
            step();
            total++;
            if (clk_out !== exp_c[k]) begin bad++; $display("FAIL sync_clk_seq edge=%0d got=%b want=%b", k+1, clk_out, exp_c[k]); end
            total++;
            if (tick !== exp_t[k]) begin bad++; $display("FAIL sync_tick_seq edge=%0d got=%b want=%b", k+1, tick, exp_t[k]); end
        end
    endtask

    task automatic test_disable();
        logic [7:0] pc;
        logic [7:0] pt;
        pc = 8'b01100110;
        pt = 8'b00100010;
        step();
        total++; if (clk_out[0] !== 1'b1) begin bad++; $display("FAIL dis_pre_clk0 got=%b want=1", clk_out[0]); end
        ch_en[0] = 1'b0;
        step();
        total++; if (clk_out[0] !== 1'b0) begin bad++; $display("FAIL dis_clk0 got=%b want=0", clk_out[0]); end
        total++; if (tick[0] !== 1'b0) begin bad++; $display("FAIL dis_tick0 got=%b want=0", tick[0]); end
        wr_en = 1'b1; wr_ch = 3'd0; wr_half = 16'd2;
        step();
        wr_en = 1'b0;
        total++; if (pend[0] !== 1'b1) begin bad++; $display("FAIL dis_pend_set got=%b want=1", pend[0]); end
        step();
        total++; if (pend[0] !== 1'b0) begin bad++; $display("FAIL dis_pend_applied got=%b want=0", pend[0]); end
        total++; if (clk_out[0] !== 1'b0) begin bad++; $display("FAIL dis_clk0_held got=%b want=0", clk_out[0]); end
        ch_en[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            total++;
            if (clk_out[0] !== pc[k]) begin bad++; $display("FAIL reen_clk0 edge=%0d got=%b want=%b", k+1, clk_out[0], pc[k]); end
            total++;
            if (tick[0] !== pt[k]) begin bad++; $display("FAIL reen_tick0 edge=%0d got=%b want=%b", k+1, tick[0], pt[k]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] pc;
        logic [5:0] pt;
        pc = 6'b100110;
        pt = 6'b100010;
        wr_en = 1'b1; wr_ch = 3'd2; wr_half = 16'd9;
        step();
        wr_half = 16'd2;
        step();
        wr_en = 1'b0;
        total++; if (pend[2] !== 1'b1) begin bad++; $display("FAIL b2b_pend2 got=%b want=1", pend[2]); end
        sync = 1'b1;
        step();
        sync = 1'b0;
        total++; if (pend !== 4'h0) begin bad++; $display("FAIL b2b_sync_pend got=%b want=0000", pend); end
        for (int k = 0; k < 6; k++) begin
            step();
            total++;
            if (clk_out[2] !== pc[k]) begin bad++; $display("FAIL b2b_clk2 edge=%0d got=%b want=%b", k+1, clk_out[2], pc[k]); end
            total++;
            if (tick[2] !== pt[k]) begin bad++; $display("FAIL b2b_tick2 edge=%0d got=%b want=%b", k+1, tick[2], pt[k]); end
        end
    endtask

    task automatic test_reset_async();
        logic [11:0] pc;
        logic [11:0] pt;
        pc = 12'b011100011100;
        pt = 12'b000100000100;
        wr_en = 1'b1; wr_ch = 3'd1; wr_half = 16'd9;
        step();
        wr_en = 1'b0;
        total++; if (pend[1] !== 1'b1) begin bad++; $display("FAIL arst_pre_pend1 got=%b want=1", pend[1]); end
        #3;
        rst = 1'b1;
        #1;
        total++; if (clk_out !== 4'h0) begin bad++; $display("FAIL arst_clk got=%b want=0000", clk_out); end
        total++; if (tick !== 4'h0) begin bad++; $display("FAIL arst_tick got=%b want=0000", tick); end
        total++; if (pend !== 4'h0) begin bad++; $display("FAIL arst_pend got=%b want=0000", pend); end
        step(); step();
        rst = 1'b0;
        wr_en = 1'b1; wr_ch = 3'd4; wr_half = 16'd9;
        for (int k = 0; k < 12; k++) begin
            step();
            wr_en = 1'b0;
            total++;
            if (clk_out !== {4{pc[k]}}) begin bad++; $display("FAIL arst_clk_seq edge=%0d got=%b want=%b", k+1, clk_out, {4{pc[k]}}); end
            total++;
            if (tick !== {4{pt[k]}}) begin bad++; $display("FAIL arst_tick_seq edge=%0d got=%b want=%b", k+1, tick, {4{pt[k]}}); end
            total++;
            if (pend !== 4'h0) begin bad++; $display("FAIL oor_pend edge=%0d got=%b want=0000", k+1, pend); end
        end
    endtask

    initial begin
        rst     = 1'b1;
        ch_en   = 4'hF;
        sync    = 1'b0;
        wr_en   = 1'b0;
        wr_ch   = 3'd0;
        wr_half = 16'd0;
        test_reset();
        test_write_mid();
        test_fast();
        test_sync();
        test_disable();
        test_back_to_back();
        test_reset_async();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
